ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be exactly:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- inValid  in  1  EX stage presents an instruction
- inReady  out  1  block can accept an instruction
- inMemRead  in  2  00 none, 01 word load, 10 byte load, 11 illegal
- inMemWrite  in  2  00 none, 01 word store, 10 byte store, 11 illegal
- inAddr  in  16  effective address from the ALU
- inWriteData  in  16  store data
- inRegWrite  in  1  instruction writes the register file
- inDestReg  in  4  destination register
- stall  in  1  downstream hold; the head entry must not advance
- flush  in  1  discard all held instructions
- outValid  out  1  head entry is valid
- memRead  out  2  to data memory
- memWrite  out  2  to data memory
- addr  out  16  to data memory
- writeData  out  16  to data memory
- regWrite  out  1  head entry writes back
- destReg  out  4  head entry destination
- misalign  out  1  sticky misaligned-access flag
- faultAddr  out  16  address of the first misaligned access

Function
REQ-003 Storage SHALL be two entries: head (drives the outputs) and skid.
REQ-004 inReady SHALL be registered and equal to 1 exactly when skid is empty.
REQ-005 An instruction SHALL be accepted on a rising edge where inValid=1, inReady=1 and flush=0.
REQ-006 The head SHALL retire on a rising edge where outValid=1 and stall=0.
REQ-007 On acceptance:
- if the head is empty or retiring in the same cycle and skid is empty, the instruction SHALL load into the head;
- otherwise it SHALL load into skid.
REQ-008 When the head retires and skid is full, skid SHALL move to the head on the same edge, and skid SHALL become empty unless a new instruction is accepted on that edge.
REQ-009 Latency SHALL be one cycle: an instruction accepted at edge N SHALL appear on the outputs after edge N when the head was empty or retiring.
REQ-010 Ordering SHALL be strict FIFO. No instruction SHALL be dropped or duplicated except by flush.
REQ-011 flush=1 at an edge SHALL empty both entries and SHALL block acceptance on that edge. flush SHALL take priority over stall.
REQ-012 memRead, memWrite and regWrite SHALL be forced to 0 whenever outValid=0. addr and writeData SHALL then hold their last values.
REQ-013 For a byte store (10), writeData SHALL equal {8'h00, inWriteData[7:0]}. For all other instructions it SHALL pass through unchanged.
REQ-014 An encoding of 11 on inMemRead or inMemWrite SHALL be stored as 00. It SHALL NOT raise misalign.
REQ-015 If both inMemRead and inMemWrite are nonzero, the write SHALL be stored as 00 and the read SHALL be kept.
REQ-016 A word access (01) with inAddr[0]=1 SHALL be stored with memRead=00, memWrite=00 and regWrite=0, and SHALL set misalign=1 at acceptance.
REQ-017 faultAddr SHALL capture inAddr only on the first misaligned acceptance while misalign=0. Later faults SHALL NOT overwrite it.
REQ-018 misalign and faultAddr SHALL be unaffected by flush. They SHALL be cleared only by reset.
REQ-019 Byte accesses SHALL have no alignment restriction.

Reset
REQ-020 While rst=0, asynchronously:
- both entries empty, outValid=0, inReady=0;
- memRead=00, memWrite=00, regWrite=0;
- addr=16'h0000, writeData=16'h0000, destReg=4'h0;
- misalign=0, faultAddr=16'h0000.
REQ-021 inReady SHALL become 1 on the first rising edge after rst deasserts.
REQ-022 Reset asserted mid-stall with both entries full SHALL discard both entries with no partial retire.

Verification
REQ-023 Word load, addr=16'h0004, regWrite=1, destReg=3, stall=0 -> next cycle outValid=1, memRead=01, addr=16'h0004, destReg=3; following cycle outValid=0, memRead=00.
REQ-024 Byte store, inWriteData=16'hBEEF, addr=16'h0009 -> memWrite=10, writeData=16'h00EF, misalign stays 0.
REQ-025 stall=1 while three instructions A, B, C are offered back to back -> A held at the head, B in skid, inReady=0, C not accepted. Release stall -> A, B, C retire in order on consecutive cycles.
REQ-026 Word store at addr=16'h0003, then word load at 16'h0005 -> both emitted with memWrite=00/memRead=00 and regWrite=0; misalign=1, faultAddr=16'h0003.
REQ-027 flush=1 together with inValid=1 while both entries are full -> next cycle outValid=0, inReady=1, flushed instruction absent; misalign unchanged.
REQ-028 rst pulsed low mid-operation -> all outputs at reset values immediately without a clock; inReady=1 after the first edge following release.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: two-entry skid buffer (head drives the memory side)
// with request sanitising and a sticky misaligned-access trap.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  output logic        inReady,
  input  logic [1:0]  inMemRead,
  input  logic [1:0]  inMemWrite,
  input  logic [15:0] inAddr,
  input  logic [15:0] inWriteData,
  input  logic        inRegWrite,
  input  logic [3:0]  inDestReg,
  input  logic        stall,
  input  logic        flush,
  output logic        outValid,
  output logic [1:0]  memRead,
  output logic [1:0]  memWrite,
  output logic [15:0] addr,
  output logic [15:0] writeData,
  output logic        regWrite,
  output logic [3:0]  destReg,
  output logic        misalign,
  output logic [15:0] faultAddr
);

  localparam int unsigned OP_W   = 2;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [OP_W-1:0] OP_NONE = 2'b00;
  localparam logic [OP_W-1:0] OP_WORD = 2'b01;
  localparam logic [OP_W-1:0] OP_BYTE = 2'b10;
  localparam logic [OP_W-1:0] OP_ILL  = 2'b11;

  typedef struct packed {
    logic [OP_W-1:0]   mem_read;
    logic [OP_W-1:0]   mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic [REG_W-1:0]  dest_reg;
  } entry_t;

  entry_t            head_q, head_d, skid_q, skid_d, in_ent;
  logic              head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic              ready_q, ready_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] fault_q, fault_d;
  logic [OP_W-1:0]   dec_rd, dec_wr;
  logic              in_mis, accept, retire;

  // Sanitise the incoming request: drop illegal codes, read wins a read/write clash,
  // misaligned word accesses become bubbles that still occupy a slot.
  always_comb begin
    dec_rd = (inMemRead  == OP_ILL) ? OP_NONE : inMemRead;
    dec_wr = (inMemWrite == OP_ILL) ? OP_NONE : inMemWrite;
    if (inMemRead != OP_NONE && inMemWrite != OP_NONE) begin
      dec_wr = OP_NONE;
    end
    in_mis = ((dec_rd == OP_WORD) || (dec_wr == OP_WORD)) && inAddr[0];

    in_ent            = '0;
    in_ent.mem_read   = in_mis ? OP_NONE : dec_rd;
    in_ent.mem_write  = in_mis ? OP_NONE : dec_wr;
    in_ent.reg_write  = in_mis ? 1'b0 : inRegWrite;
    in_ent.addr       = inAddr;
    in_ent.dest_reg   = inDestReg;
    in_ent.write_data = (dec_wr == OP_BYTE)
                        ? {BYTE_W'(0), inWriteData[BYTE_W-1:0]}
                        : inWriteData;
  end

  // Next-state for the two entries, ready flag and fault trap.
  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    accept     = inValid & ready_q & ~flush;
    retire     = head_vld_q & ~stall;

    if (flush) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (retire && skid_vld_q) begin
      head_d     = skid_q;
      head_vld_d = 1'b1;
      skid_vld_d = accept;
      if (accept) begin
        skid_d = in_ent;
      end
    end else if (retire || !head_vld_q) begin
      head_vld_d = accept;
      if (accept) begin
        head_d = in_ent;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end

    // An empty head shows no memory/writeback request; address and data hold.
    if (!head_vld_d) begin
      head_d.mem_read  = OP_NONE;
      head_d.mem_write = OP_NONE;
      head_d.reg_write = 1'b0;
    end

    ready_d    = ~skid_vld_d;
    misalign_d = misalign_q | (accept & in_mis);
    fault_d    = (accept && in_mis && !misalign_q) ? inAddr : fault_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b0;
      misalign_q <= 1'b0;
      fault_q    <= '0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= ready_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
    end
  end

  assign inReady   = ready_q;
  assign outValid  = head_vld_q;
  assign memRead   = head_q.mem_read;
  assign memWrite  = head_q.mem_write;
  assign addr      = head_q.addr;
  assign writeData = head_q.write_data;
  assign regWrite  = head_q.reg_write;
  assign destReg   = head_q.dest_reg;
  assign misalign  = misalign_q;
  assign faultAddr = fault_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios plus random traffic, all checked
// against a queue-based FIFO reference model.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [1:0]  inMemRead = '0;
  logic [1:0]  inMemWrite = '0;
  logic [15:0] inAddr = '0;
  logic [15:0] inWriteData = '0;
  logic        inRegWrite = 1'b0;
  logic [3:0]  inDestReg = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        outValid;
  logic [1:0]  memRead, memWrite;
  logic [15:0] addr, writeData;
  logic        regWrite;
  logic [3:0]  destReg;
  logic        misalign;
  logic [15:0] faultAddr;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inAddr(inAddr),
    .inWriteData(inWriteData), .inRegWrite(inRegWrite), .inDestReg(inDestReg),
    .stall(stall), .flush(flush), .outValid(outValid), .memRead(memRead),
    .memWrite(memWrite), .addr(addr), .writeData(writeData), .regWrite(regWrite),
    .destReg(destReg), .misalign(misalign), .faultAddr(faultAddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [15:0] a;
    logic [15:0] d;
    logic        rw;
    logic [3:0]  dr;
  } ent_t;

  ent_t        q[$];
  logic        m_ready = 1'b0;
  logic        m_mis = 1'b0;
  logic [15:0] m_fault = '0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wd = '0;
  logic [3:0]  m_dest = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic v;
    ent_t h;
    v = (q.size() > 0);
    h = '{rd: 2'b00, wr: 2'b00, a: 16'h0, d: 16'h0, rw: 1'b0, dr: 4'h0};
    if (v) h = q[0];
    check("outValid", 32'(outValid), 32'(v));
    check("inReady", 32'(inReady), 32'(m_ready));
    check("memRead", 32'(memRead), 32'(h.rd));
    check("memWrite", 32'(memWrite), 32'(h.wr));
    check("regWrite", 32'(regWrite), 32'(h.rw));
    check("addr", 32'(addr), 32'(m_addr));
    check("writeData", 32'(writeData), 32'(m_wd));
    check("destReg", 32'(destReg), 32'(m_dest));
    check("misalign", 32'(misalign), 32'(m_mis));
    check("faultAddr", 32'(faultAddr), 32'(m_fault));
  endtask

  task automatic check_reset();
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_inReady", 32'(inReady), 32'd0);
    check("rst_memRead", 32'(memRead), 32'd0);
    check("rst_memWrite", 32'(memWrite), 32'd0);
    check("rst_regWrite", 32'(regWrite), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_writeData", 32'(writeData), 32'd0);
    check("rst_destReg", 32'(destReg), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_faultAddr", 32'(faultAddr), 32'd0);
  endtask

  // Drive one cycle of inputs and advance the reference model across the coming edge.
  task automatic step(input logic v, input logic [1:0] mr, input logic [1:0] mw,
                      input logic [15:0] a, input logic [15:0] d, input logic rw,
                      input logic [3:0] dr, input logic st, input logic fl);
    ent_t e;
    logic acc, ret, mis;
    logic [1:0] rd, wr;
    inValid = v; inMemRead = mr; inMemWrite = mw; inAddr = a; inWriteData = d;
    inRegWrite = rw; inDestReg = dr; stall = st; flush = fl;

    rd = (mr == 2'b11) ? 2'b00 : mr;
    wr = (mw == 2'b11) ? 2'b00 : mw;
    if (mr != 2'b00 && mw != 2'b00) wr = 2'b00;
    mis = (rd == 2'b01 || wr == 2'b01) && a[0];
    e.d  = (wr == 2'b10) ? {8'h00, d[7:0]} : d;
    e.rd = mis ? 2'b00 : rd;
    e.wr = mis ? 2'b00 : wr;
    e.rw = mis ? 1'b0 : rw;
    e.a  = a;
    e.dr = dr;

    acc = v && m_ready && !fl;
    ret = (q.size() > 0) && !st;
    if (fl) begin
      q.delete();
    end else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (acc && mis) begin
      if (!m_mis) m_fault = a;
      m_mis = 1'b1;
    end
    if (q.size() > 0) begin
      m_addr = q[0].a;
      m_wd   = q[0].d;
      m_dest = q[0].dr;
    end
    m_ready = (q.size() < 2);
  endtask

  task automatic cyc(input logic v, input logic [1:0] mr, input logic [1:0] mw,
                     input logic [15:0] a, input logic [15:0] d, input logic rw,
                     input logic [3:0] dr, input logic st, input logic fl);
    @(negedge clk);
    check_outputs();
    step(v, mr, mw, a, d, rw, dr, st, fl);
  endtask

  task automatic idle(input logic st);
    cyc(1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 4'h0, st, 1'b0);
  endtask

  task automatic model_clear();
    q.delete();
    m_ready = 1'b0; m_mis = 1'b0; m_fault = '0;
    m_addr = '0; m_wd = '0; m_dest = '0;
  endtask

  // Asynchronous reset pulse taken between clock edges.
  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    #2 rst = 1'b0;
    #1 check_reset();
    model_clear();
    inValid = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_reset();
    rst = 1'b1;
    step(1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #3 check_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0);

    // Word load, then bubble.
    cyc(1'b1, 2'b01, 2'b00, 16'h0004, 16'h1234, 1'b1, 4'd3, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Byte store at an odd address.
    cyc(1'b1, 2'b00, 2'b10, 16'h0009, 16'hBEEF, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("byte_store_data", 32'(writeData), 32'h0000_00EF);
    check("byte_store_nomis", 32'(misalign), 32'd0);
    step(1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0);

    // Illegal encodings and read/write clash.
    cyc(1'b1, 2'b11, 2'b11, 16'h0011, 16'h5555, 1'b1, 4'd5, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 2'b01, 16'h0013, 16'hA5A5, 1'b1, 4'd6, 1'b0, 1'b0);
    idle(1'b0);

    // Stall with A, B, C offered back to back; C must be refused.
    cyc(1'b1, 2'b01, 2'b00, 16'h0100, 16'h0, 1'b1, 4'd1, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 2'b00, 16'h0200, 16'h0, 1'b1, 4'd2, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 2'b00, 16'h0300, 16'h0, 1'b1, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    check("stall_ready_low", 32'(inReady), 32'd0);
    check("stall_head_A", 32'(addr), 32'h0100);
    step(1'b1, 2'b01, 2'b00, 16'h0300, 16'h0, 1'b1, 4'd3, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0); idle(1'b0);

    // Fresh fault trap: first misaligned address is kept.
    do_reset();
    cyc(1'b1, 2'b00, 2'b01, 16'h0003, 16'h7777, 1'b0, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 2'b00, 16'h0005, 16'h0, 1'b1, 4'd7, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    check("fault_addr_first", 32'(faultAddr), 32'h0003);

    // Flush with both entries full and a new instruction offered.
    cyc(1'b1, 2'b01, 2'b00, 16'h0400, 16'h0, 1'b1, 4'd4, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 2'b01, 16'h0402, 16'h1111, 1'b0, 4'd0, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 2'b00, 16'h0404, 16'h0, 1'b1, 4'd8, 1'b1, 1'b1);
    idle(1'b0); idle(1'b0);

    // Reset while stalled with both entries full.
    cyc(1'b1, 2'b01, 2'b00, 16'h0500, 16'h0, 1'b1, 4'd9, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 2'b00, 16'h0502, 16'h0, 1'b1, 4'd10, 1'b1, 1'b0);
    do_reset();
    idle(1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      cyc($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom), ra, 16'($urandom),
          1'($urandom), 4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
      if (i == 1500) do_reset();
    end
    @(negedge clk);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
